// File: rtl/hazard_unit_md.sv
// Hazard controller: forwarding, load-use stall, branch flush, multi-cycle mul/div hold in Execute.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_unit_md #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic [1:0]        ResultSrcE,
    input  logic              MulDivE,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdBusy,
    output logic              MdDone,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] MD_INIT = 8'(MD_LAT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       lw_stall, md_stall, md_done;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && Rs1E != '0 && Rs1E == RdM)      ForwardAE = 2'b10;
        else if (RegWriteW && Rs1E != '0 && Rs1E == RdW) ForwardAE = 2'b01;
        if (RegWriteM && Rs2E != '0 && Rs2E == RdM)      ForwardBE = 2'b10;
        else if (RegWriteW && Rs2E != '0 && Rs2E == RdW) ForwardBE = 2'b01;
    end

    // A load tagged as mul/div is handled by the mul/div path, not the load-use path.
    assign lw_stall = (ResultSrcE == 2'b01) && !MulDivE && (RdE != '0)
                   && ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_stall  = 1'b0;
        md_done   = 1'b0;
        if (!rst_n) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    md_stall = MulDivE;
                    if (MulDivE) begin
                        cnt_nxt   = MD_INIT;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    cnt_nxt  = cnt - 8'd1;
                    md_stall = (cnt != 8'd1);
                    md_done  = (cnt == 8'd1);
                    if (cnt == 8'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The held op must never be killed, so the mul/div stall masks every flush into E/D.
    assign StallF = lw_stall | md_stall;
    assign StallD = lw_stall | md_stall;
    assign StallE = md_stall;
    assign FlushM = md_stall;
    assign FlushD = PCSrcE & ~md_stall;
    assign FlushE = (PCSrcE | lw_stall) & ~md_stall;
    assign MdBusy = rst_n & (state == BUSY);
    assign MdDone = md_done;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (FlushE && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_md.sv
// Bench for hazard_unit_md: vector table, hand sequences and random stimulus vs a cycle-age model.
module tb_hazard_unit_md;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic RegWriteM, RegWriteW, PCSrcE, MulDivE;
    logic [1:0] ResultSrcE;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int tests = 0;
    int fails = 0;

    // Model: age = cycles the current mul/div op has already spent in E (0 = none).
    int age = 0;
    int m_sc = 0, m_fc = 0;
    logic e_stall, e_flushe;

    hazard_unit_md #(.REG_AW(5), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE), .MulDivE(MulDivE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
        .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MdDone(MdDone), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs != 0 && rs == RdM && RegWriteM) return 2'b10;
        if (rs != 0 && rs == RdW && RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        rst_n = 1'b1; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MulDivE = 0;
        ResultSrcE = 2'b00; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    endtask

    // Compare every output against the model, then clock and advance the model.
    task automatic step();
        logic lw, md, done, busy;
        #2;
        lw = (ResultSrcE == 2'b01) && !MulDivE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        if (!rst_n)        begin md = 0; done = 0; busy = 0; end
        else if (age == 0) begin md = MulDivE; done = 0; busy = 0; end
        else begin
            busy = 1;
            done = (age == MD_LAT - 1);
            md   = (age < MD_LAT - 1);
        end
        e_stall  = lw | md;
        e_flushe = (PCSrcE | lw) & ~md;
        chk("m_fwdA", ForwardAE, fwd(Rs1E));
        chk("m_fwdB", ForwardBE, fwd(Rs2E));
        chk("m_stallF", StallF, e_stall);
        chk("m_stallD", StallD, e_stall);
        chk("m_stallE", StallE, md);
        chk("m_flushM", FlushM, md);
        chk("m_flushD", FlushD, PCSrcE & ~md);
        chk("m_flushE", FlushE, e_flushe);
        chk("m_busy", MdBusy, busy);
        chk("m_done", MdDone, done);
`ifdef HAZARD_PERF_EN
        chk("m_stallcnt", StallCnt, m_sc);
        chk("m_flushcnt", FlushCnt, m_fc);
`else
        chk("m_stallcnt", StallCnt, 0);
        chk("m_flushcnt", FlushCnt, 0);
`endif
        @(posedge clk);
        if (!rst_n) begin
            age = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (age == 0) age = MulDivE ? 1 : 0;
            else age = (age == MD_LAT - 1) ? 0 : age + 1;
            if (e_stall)  m_sc = (m_sc == CMAX) ? CMAX : m_sc + 1;
            if (e_flushe) m_fc = (m_fc == CMAX) ? CMAX : m_fc + 1;
        end
        #1;
    endtask

    typedef struct {
        logic [4:0] rs1e, rs2e, rdm, rdw;
        logic       rwm, rww;
        logic [4:0] rs1d, rs2d, rde;
        logic [1:0] rsrc;
        logic       pcsrc;
        logic [1:0] fa, fb;
        logic       stall, fd, fe;
    } vec_t;

    vec_t vecs[8];
    logic [4:0] e_st, e_done, e_busy;

    initial begin
        vecs[0] = '{5, 0, 5, 5, 1, 1, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0};
        vecs[1] = '{3, 0, 0, 3, 1, 1, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0};
        vecs[2] = '{4, 4, 4, 4, 0, 1, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 0, 0, 0};
        vecs[3] = '{4, 6, 6, 4, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 0, 0, 0};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 7, 7, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 1, 1};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 7, 0, 7, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0};

        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        // Reset state: MulDivE requested during reset must not stall.
        MulDivE = 1;
        #1;
        chk("rst_stallE", StallE, 0);
        chk("rst_busy", MdBusy, 0);
        step();
        idle_inputs();
        step();

        foreach (vecs[i]) begin
            idle_inputs();
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; RdE = vecs[i].rde;
            ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc;
            #1;
            chk($sformatf("v%0d_fwdA", i), ForwardAE, vecs[i].fa);
            chk($sformatf("v%0d_fwdB", i), ForwardBE, vecs[i].fb);
            chk($sformatf("v%0d_stallF", i), StallF, vecs[i].stall);
            chk($sformatf("v%0d_stallD", i), StallD, vecs[i].stall);
            chk($sformatf("v%0d_flushD", i), FlushD, vecs[i].fd);
            chk($sformatf("v%0d_flushE", i), FlushE, vecs[i].fe);
            step();
        end

        // Mul/div hold: bit i of each mask is the required value in cycle i.
        e_st = 5'b00111; e_done = 5'b01000; e_busy = 5'b01110;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            MulDivE = (c < 4);
            #1;
            chk($sformatf("md_stallE_c%0d", c), StallE, e_st[c]);
            chk($sformatf("md_flushM_c%0d", c), FlushM, e_st[c]);
            chk($sformatf("md_done_c%0d", c), MdDone, e_done[c]);
            chk($sformatf("md_busy_c%0d", c), MdBusy, e_busy[c]);
            step();
        end

        // Branch during BUSY with cnt=2 (cycle 2) must not flush; in IDLE it must.
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            MulDivE = (c == 0);
            PCSrcE  = (c == 2) || (c == 4);
            #1;
            if (c == 2) begin
                chk("pri_busy_flushD", FlushD, 0);
                chk("pri_busy_flushE", FlushE, 0);
            end
            if (c == 4) begin
                chk("pri_idle_flushD", FlushD, 1);
                chk("pri_idle_flushE", FlushE, 1);
            end
            step();
        end

        // Reset at cnt=2 aborts the op without a completion pulse.
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            MulDivE = (c == 0);
            rst_n   = (c != 2);
            #1;
            if (c == 2) begin
                chk("rmid_stallF", StallF, 0);
                chk("rmid_stallE", StallE, 0);
                chk("rmid_busy", MdBusy, 0);
            end
            if (c == 3) chk("rmid_idle_busy", MdBusy, 0);
            if (c >= 2) chk($sformatf("rmid_done_c%0d", c), MdDone, 0);
            step();
        end

        // 20 consecutive load-use stall cycles saturate the 4-bit counter.
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
            step();
        end
        idle_inputs();
        #1;
`ifdef HAZARD_PERF_EN
        chk("sat_stallcnt", StallCnt, 15);
        chk("sat_flushcnt", FlushCnt, 15);
`else
        chk("sat_stallcnt", StallCnt, 0);
        chk("sat_flushcnt", FlushCnt, 0);
`endif
        step();

        for (int c = 0; c < 400; c++) begin
            rst_n      = ($urandom_range(0, 39) != 0);
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            MulDivE    = ($urandom_range(0, 4) == 0);
            ResultSrcE = 2'($urandom_range(0, 3));
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit_md.md
# hazard_unit_md

Pipeline hazard controller for the five-stage RISC-V core, extending the existing forwarding/load-use/branch-flush logic with support for a multi-cycle multiply/divide unit in the Execute stage. It sits beside the datapath and drives stall, flush and forwarding selects for all stages. An internal FSM and down-counter hold the op in Execute for a parametrised latency. Optional saturating performance counters track stall and flush cycles.

## Interface
- REG_AW, 5: register address width.
- MD_LAT, 4: total Execute-stage cycles of a mul/div op; legal range 2..255.
- CNT_W, 32: performance counter width.

- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- RegWriteM, RegWriteW  in  1 each  write-enable of instruction in M / W.
- PCSrcE  in  1  taken branch/jump resolved in E.
- ResultSrcE  in  2  result select of E instruction; 2'b01 = load.
- MulDivE  in  1  E instruction is a mul/div op.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW each  register indices.
- StallF, StallD, StallE  out  1 each  hold PC / IF-ID / ID-EX registers.
- FlushD, FlushE, FlushM  out  1 each  clear IF-ID / ID-EX / EX-MEM registers.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 regfile, 01 W result, 10 M ALU result.
- MdBusy  out  1  FSM in BUSY.
- MdDone  out  1  mul/div result valid in E this cycle.
- StallCnt, FlushCnt  out  CNT_W each  performance counters.

## Operation
- Forwarding (combinational, per operand X in {A,B}): 10 if RsXE==RdM & RegWriteM & RsXE!=0; else 01 if RsXE==RdW & RegWriteW & RsXE!=0; else 00. M has priority over W.
- lwStall = (ResultSrcE==01) & ~MulDivE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). No stall on x0.
- FSM states IDLE, BUSY; 8-bit counter cnt.
  - IDLE: if MulDivE & rst_n -> cnt<=MD_LAT-1, go BUSY. mdStall=MulDivE.
  - BUSY: cnt<=cnt-1; mdStall=(cnt!=1); MdDone=(cnt==1); when cnt==1 -> IDLE.
  - MulDivE ignored while BUSY. Back-to-back mul/div: new op enters E cycle after MdDone, starts from IDLE.
- Outputs:
  - StallF=StallD=lwStall|mdStall; StallE=mdStall; FlushM=mdStall.
  - FlushD=PCSrcE & ~mdStall; FlushE=(PCSrcE|lwStall) & ~mdStall.
  - mdStall dominates: no flush may kill an op held in E. MulDivE with ResultSrcE==01 is treated as mul/div.
- MdBusy = (state==BUSY).
- Mul/div unit captures operands in the IDLE entry cycle; forwarding selects are valid that cycle.

## Timing
- Stall/flush/forward outputs combinational from inputs and registered state, same cycle.
- Mul/div op occupies E for exactly MD_LAT cycles; stall asserted the first MD_LAT-1; MdDone the last; pipeline advances on the clock edge ending the MdDone cycle.
- MD_LAT=2: IDLE cycle stalls, single BUSY cycle with cnt=1 gives MdDone.
- Reset: while rst_n=0, mdStall, MdDone, MdBusy forced 0; next state IDLE, cnt=0, counters=0. Reset mid-op aborts; no MdDone issued. lwStall, FlushD, forwarding remain combinational through reset.

## Configuration
- HAZARD_PERF_EN defined: StallCnt increments on each cycle StallF=1, FlushCnt on each cycle FlushE=1; both saturate at all-ones; clear on reset.
- Undefined: counters not instantiated; StallCnt and FlushCnt tied to 0. All other behaviour identical.

## Test plan
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; Rs2E=0, RdM=0, RegWriteM=1 -> ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; RdE=0 -> no stall.
- Mul/div MD_LAT=4: MulDivE=1 held -> StallE=FlushM=1 cycles 0-2, MdDone=1 only cycle 3, MdBusy=1 cycles 1-3, IDLE cycle 4.
- Priority: PCSrcE=1 during BUSY with cnt=2 -> FlushD=FlushE=0; with state IDLE, MulDivE=0 -> FlushD=FlushE=1.
- Reset mid-op: rst_n=0 at cnt=2 -> next cycle IDLE, MdDone never asserted, stalls 0 during reset.
- HAZARD_PERF_EN, CNT_W=4: 20 consecutive stall cycles -> StallCnt=15 held; macro off -> StallCnt=0.
